montgomery_ctrl: RTL
====================

MONTGOMERY_CTRL -- requirements
Module: montgomery_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 1024, operand width in bits.
REQ-002 SHALL have port: clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port: resetn  input  1  synchronous reset, active-low.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have ports: in_a, in_b, in_m  input  WIDTH each  operands A, B, modulus M; captured on the accepted start.
REQ-006 SHALL have port: result  output  WIDTH  A*B*2^-WIDTH mod M; valid from done onward.
REQ-007 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-008 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port: add_start  output  1  one-cycle adder launch.
REQ-010 SHALL have port: add_subtract  output  1  1 = in_a minus in_b, 0 = sum.
REQ-011 SHALL have port: add_shift  output  1  tied 0.
REQ-012 SHALL have ports: add_in_a  output  WIDTH+2, and add_in_b  output  WIDTH+2 (zero-extended)  adder operands.
REQ-013 SHALL have ports: add_result  input  WIDTH+2  adder sum or difference, mod 2^(WIDTH+2); add_done  input  1  result valid.

Function
REQ-014 SHALL compute C=0; for i=0..WIDTH-1: if A[i] then C=C+B; if C odd then C=C+M; C=C>>1; final: if C>=M then C=C-M.
REQ-015 SHALL hold C in a WIDTH+2-bit register; legal operands are M odd, A<M, B<M; intermediate sums <4M fit without overflow.
REQ-016 SHALL use states IDLE, ADDB_ISSUE, ADDB_WAIT, ADDM_ISSUE, ADDM_WAIT, SHIFT, SUB_ISSUE, SUB_WAIT, DONE.
REQ-017 Transitions: IDLE -> ADDB_ISSUE on start, capturing operands, C=0, i=0.
REQ-018 Transitions: ADDB_ISSUE -> ADDB_WAIT; ADDB_WAIT -> ADDM_ISSUE if the captured result is odd, else SHIFT.
REQ-019 Transitions: ADDM_ISSUE -> ADDM_WAIT -> SHIFT.
REQ-020 Transitions: SHIFT -> ADDB_ISSUE if i<WIDTH-1 (i incremented), else SUB_ISSUE.
REQ-021 Transitions: SUB_ISSUE -> SUB_WAIT -> DONE -> IDLE.
REQ-022 ADDB_ISSUE: add_in_b = A[i] ? B : 0.
REQ-023 Each *_ISSUE state SHALL assert add_start for exactly one cycle, with add_in_a=C and add_in_b and add_subtract stable until the matching *_WAIT exits.
REQ-024 Each *_WAIT state SHALL stay until add_done=1, then load add_result into C; add_done in the ISSUE cycle is ignored.
REQ-025 SUB_WAIT SHALL keep C if add_result bit WIDTH+1 is set (negative), else load add_result[WIDTH-1:0].
REQ-026 result SHALL register C[WIDTH-1:0] on DONE entry and hold it until the next accepted start.
REQ-027 done SHALL be high only in the DONE cycle.
REQ-028 Latency with add_done held high, feature disabled, A=0: done high exactly 3*WIDTH+3 cycles after the start-sampling edge.
REQ-029 Adder stalls SHALL add one cycle of latency per cycle add_done is low and SHALL NOT change result.
REQ-030 start while busy SHALL be ignored, with no queuing.
REQ-031 start in the DONE cycle SHALL be ignored; start is accepted from the following IDLE cycle.

Reset
REQ-032 resetn=0 at a clock edge SHALL force IDLE, C=0, i=0, result=0, done=0, busy=0, add_start=0, add_subtract=0.
REQ-033 Reset mid-operation SHALL abandon the computation; an add_done arriving after reset SHALL be ignored.

Configuration
REQ-034 Macro MONT_SKIP_ZERO_EN SHALL, when defined, make SHIFT and IDLE go directly to ADDM_ISSUE when A[i]=0 and C is odd, and directly to SHIFT when A[i]=0 and C is even, issuing no adder operation for that bit.
REQ-035 With MONT_SKIP_ZERO_EN defined, A=0 latency SHALL be WIDTH+3 cycles.
REQ-036 Without MONT_SKIP_ZERO_EN, ADDB_ISSUE SHALL execute for every bit; results SHALL be identical in both builds.

Verification (WIDTH=8, ideal adder unless stated)
REQ-037 A=5, B=7, M=13 -> result=1, single done pulse.
REQ-038 A=12, B=12, M=13 -> result=3; A=1, B=1, M=13 -> result=3.
REQ-039 A=0, B=7, M=13 -> result=0; done at cycle 27 without the macro, cycle 11 with it.
REQ-040 A=5, B=7, M=13 with add_done held low 4 cycles on every op -> result=1, latency increased by 4 x (number of ops).
REQ-041 resetn low for 1 cycle at cycle 10 of a run, then start A=1, B=1, M=13 -> result=3; no spurious done.
REQ-042 start pulsed repeatedly while busy -> exactly one done per accepted start, result unchanged.

Source files
------------

// File: rtl/montgomery_ctrl_if.sv
//------------------------------------------------------------------------------
// montgomery_ctrl_if
// Request/result and external-adder signal bundle for montgomery_ctrl.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface montgomery_ctrl_if #(
  parameter int WIDTH = 1024
);
  logic             start;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_m;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;
  logic             add_start;
  logic             add_subtract;
  logic             add_shift;
  logic [WIDTH+1:0] add_in_a;
  logic [WIDTH+1:0] add_in_b;
  logic [WIDTH+1:0] add_result;
  logic             add_done;

  // slave: the controller; master: requester plus adder environment
  modport slave (
    input  start, in_a, in_b, in_m, add_result, add_done,
    output result, done, busy, add_start, add_subtract, add_shift, add_in_a, add_in_b
  );

  modport master (
    output start, in_a, in_b, in_m, add_result, add_done,
    input  result, done, busy, add_start, add_subtract, add_shift, add_in_a, add_in_b
  );
endinterface

`default_nettype wire

// File: rtl/montgomery_ctrl.sv
//------------------------------------------------------------------------------
// montgomery_ctrl
// Bit-serial Montgomery multiplier controller driving an external WIDTH+2 adder.
// Optional macro MONT_SKIP_ZERO_EN skips the adder launch for zero bits of A.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module montgomery_ctrl #(
  parameter int WIDTH = 1024
) (
  input  wire logic         clk,
  input  wire logic         resetn,
  montgomery_ctrl_if.slave  bus
);

  localparam int             c_IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_BIT = c_IDX_W'(WIDTH - 1);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    ADDB_ISSUE = 4'd1,
    ADDB_WAIT  = 4'd2,
    ADDM_ISSUE = 4'd3,
    ADDM_WAIT  = 4'd4,
    SHIFT      = 4'd5,
    SUB_ISSUE  = 4'd6,
    SUB_WAIT   = 4'd7,
    DONE       = 4'd8
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH+1:0]     c_q, c_d;
  logic [c_IDX_W-1:0]   i_q, i_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     result_q, result_d;

  logic [WIDTH+1:0]     w_c_shift;
  logic [c_IDX_W-1:0]   w_i_next;
  logic [WIDTH+1:0]     w_add_in_b;

  assign w_c_shift = c_q >> 1;
  assign w_i_next  = i_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      c_q      <= '0;
      i_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      i_q      <= i_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    i_d      = i_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d = bus.in_a;
          b_d = bus.in_b;
          m_d = bus.in_m;
          c_d = '0;
          i_d = '0;
`ifdef MONT_SKIP_ZERO_EN
          // C is zero here, so a clear A[0] can only lead to a plain shift
          state_d = bus.in_a[0] ? ADDB_ISSUE : SHIFT;
`else
          state_d = ADDB_ISSUE;
`endif
        end
      end
      ADDB_ISSUE: state_d = ADDB_WAIT;
      ADDB_WAIT: begin
        if (bus.add_done) begin
          c_d     = bus.add_result;
          state_d = bus.add_result[0] ? ADDM_ISSUE : SHIFT;
        end
      end
      ADDM_ISSUE: state_d = ADDM_WAIT;
      ADDM_WAIT: begin
        if (bus.add_done) begin
          c_d     = bus.add_result;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        c_d = w_c_shift;
        if (i_q == c_LAST_BIT) begin
          state_d = SUB_ISSUE;
        end else begin
          i_d = w_i_next;
`ifdef MONT_SKIP_ZERO_EN
          if (a_q[w_i_next])     state_d = ADDB_ISSUE;
          else if (w_c_shift[0]) state_d = ADDM_ISSUE;
          else                   state_d = SHIFT;
`else
          state_d = ADDB_ISSUE;
`endif
        end
      end
      SUB_ISSUE: state_d = SUB_WAIT;
      SUB_WAIT: begin
        if (bus.add_done) begin
          // Top bit set means C < M: the subtraction is discarded
          if (bus.add_result[WIDTH+1]) begin
            result_d = c_q[WIDTH-1:0];
          end else begin
            c_d      = {2'b00, bus.add_result[WIDTH-1:0]};
            result_d = bus.add_result[WIDTH-1:0];
          end
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    w_add_in_b = '0;
    case (state_q)
      ADDB_ISSUE, ADDB_WAIT:                    w_add_in_b = a_q[i_q] ? {2'b00, b_q} : '0;
      ADDM_ISSUE, ADDM_WAIT, SUB_ISSUE, SUB_WAIT: w_add_in_b = {2'b00, m_q};
      default:                                  w_add_in_b = '0;
    endcase
  end

  assign bus.add_in_a     = c_q;
  assign bus.add_in_b     = w_add_in_b;
  assign bus.add_start    = (state_q == ADDB_ISSUE) || (state_q == ADDM_ISSUE) || (state_q == SUB_ISSUE);
  assign bus.add_subtract = (state_q == SUB_ISSUE) || (state_q == SUB_WAIT);
  assign bus.add_shift    = 1'b0;
  assign bus.done         = (state_q == DONE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.result       = result_q;

endmodule

`default_nettype wire
